// File: rtl/prio_enc_pkg.sv
// prio_enc_pkg: shared mode encoding and output width helper for the request encoder
package prio_enc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int out_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prio_rr_pick.sv
// prio_rr_pick: combinational find-first-set starting at a pointer (round-robin) or at 0 (fixed)
module prio_rr_pick
  import prio_enc_pkg::*;
#(
  parameter int N = 16,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  mode_e         mode,
  output logic          found,
  output logic [PW-1:0] idx
);

  localparam logic [PW:0] NW = (PW + 1)'(N);

  logic [PW-1:0] start;
  logic [PW-1:0] off;
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  logic [PW:0] sum;

  // rotate so the search origin sits at bit 0, find the lowest set bit, then undo the rotation
  always_comb begin
    start = (mode == MODE_RR) ? ptr : '0;
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? i[PW-1:0] : off;
    sum = {1'b0, start} + {1'b0, off};
    idx = (sum >= NW) ? PW'(sum - NW) : sum[PW-1:0];
    found = |req;
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: sticky request capture with one registered grant per valid/ready transfer
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter int N_REQ = 16,
  localparam int OUT_W = out_width(N_REQ)
) (
  input  logic             clk_dut,
  input  logic             rst_dut,
  input  logic             enable_dut,
  input  logic             mode_dut,
  input  logic [N_REQ-1:0] encoder_in_dut,
  input  logic             ready_in_dut,
  output logic [OUT_W-1:0] binary_out_dut,
  output logic             valid_out_dut,
  output logic [N_REQ-1:0] pending_dut
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  logic [N_REQ-1:0] pend_q, pend_d, load_mask;
  logic [PW-1:0]    ptr_q, ptr_d, pick_idx;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             slot_free, load, found;
  mode_e            mode;

  assign mode = mode_e'(mode_dut);

  prio_rr_pick #(.N(N_REQ)) u_pick (
    .req   (pend_q),
    .ptr   (ptr_q),
    .mode  (mode),
    .found (found),
    .idx   (pick_idx)
  );

  // handshake: load a new grant whenever the slot frees up; a re-request of the loaded bit wins over its clear
  always_comb begin
    slot_free = !valid_q || ready_in_dut;
    load = slot_free && found;
    load_mask = load ? (N_REQ'(1) << pick_idx) : '0;
    pend_d = (pend_q & ~load_mask) | (enable_dut ? encoder_in_dut : '0);
    valid_d = slot_free ? found : valid_q;
    bin_d = load ? OUT_W'(pick_idx) + OUT_W'(1) : (slot_free ? '0 : bin_q);
    ptr_d = (load && mode == MODE_RR) ? ((pick_idx == LAST) ? '0 : pick_idx + 1'b1) : ptr_q;
  end

  // state registers; reset drops any in-flight grant immediately
  always_ff @(posedge clk_dut or posedge rst_dut) begin
    if (rst_dut) begin
      pend_q <= '0;
      ptr_q <= '0;
      bin_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      bin_q <= bin_d;
      valid_q <= valid_d;
    end
  end

  assign binary_out_dut = bin_q;
  assign valid_out_dut = valid_q;
  assign pending_dut = pend_q;

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the team's 16-input combinational priority encoder.
- Captures request pulses into a sticky pending vector and grants them one per transfer over a valid/ready output.
- Grant order is selectable: fixed (lowest index wins) or round-robin.
- Sits between request sources (interrupt/event lines) and a single consumer that services one index at a time.

Parameters:
- N_REQ, 16, number of request lines; legal range 2..64.
- OUT_W, $clog2(N_REQ+1), derived localparam; output code width; not overridable.

Ports:
- clk_dut  input  1  single clock; all state updates on rising edge.
- rst_dut  input  1  asynchronous, active-high reset.
- enable_dut  input  1  1 = capture encoder_in_dut into pending; 0 = ignore new requests.
- mode_dut  input  1  0 = fixed priority; 1 = round-robin.
- encoder_in_dut  input  N_REQ  request vector, sampled each clock edge.
- ready_in_dut  input  1  consumer accepts binary_out_dut this cycle.
- binary_out_dut  output  OUT_W  granted index+1; 0 = no grant.
- valid_out_dut  output  1  binary_out_dut holds a grant.
- pending_dut  output  N_REQ  current pending vector, registered.

Behaviour:
- Reset, asynchronous and immediate:
  - binary_out_dut=0, valid_out_dut=0, pending_dut=0, rr pointer=0.
  - Any in-flight grant is discarded.
- Output slot is free when valid_out_dut=0 or (valid_out_dut=1 and ready_in_dut=1).
- Load: if the slot is free and pending≠0, select index k from the current registered pending vector:
  - mode 0: lowest set index.
  - mode 1: first set index searching upward from ptr, wrapping N_REQ-1→0.
- On load:
  - binary_out_dut←k+1, valid_out_dut←1.
  - Bit k is cleared from pending.
  - In mode 1, ptr←(k+1) mod N_REQ.
- Slot free and pending=0: valid_out_dut←0, binary_out_dut←0.
- Stall: when valid_out_dut=1 and ready_in_dut=0, binary_out_dut and valid_out_dut hold stable and pending keeps accumulating.
- Pending update each edge: pending←(pending & ~load_mask) | (enable_dut ? encoder_in_dut : 0).
  - Set wins: if a bit is loaded and requested again in the same cycle, it stays pending.
- Latency:
  - A request sampled at edge t appears in pending_dut after edge t.
  - The earliest grant is visible after edge t+1.
  - With ready_in_dut held at 1, one grant is issued per cycle.
- Requests already pending collapse: repeated pulses on the same bit give one grant.
- Mode may change at any cycle and applies at the next load. ptr is retained in mode 0 but not updated.
- enable_dut=0 blocks capture only; pending and the output continue to drain.
- Width: OUT_W must encode N_REQ (e.g. N_REQ=16 → OUT_W=5, code 16 = index 15).
- No combinational path from inputs to outputs.

Decomposition:
- Package prio_enc_pkg:
  - Mode enum: MODE_FIXED=0, MODE_RR=1.
  - Function out_width(n) returning $clog2(n+1).
- Sub-module prio_rr_pick (combinational):
  - Inputs: req vector, start pointer, mode.
  - Outputs: found flag, index.
  - Implementation: rotate, find-first, unrotate.
- Top module holds the pending register, ptr, output register and handshake.

Test Plan:
- Reset mid-stall with pending=0x00F0 and valid_out_dut=1; assert rst_dut between edges → all outputs and pending drop to 0 immediately, without a clock edge.
- Fixed priority:
  - Stimulus: mode=0, enable=1, one-cycle pulse encoder_in_dut=0x0014 at edge t, ready held 1.
  - Response: pending=0x0014 after t; binary_out_dut=3 after t+1; binary_out_dut=5 after t+2; valid=0 and binary_out_dut=0 after t+3.
- Round-robin:
  - Stimulus: mode=1, ptr=0, pulse 0x8001, ready=1.
  - Response: grants 1 then 16. Then pulse 0x8001 again → grants 1, 16 again (ptr has wrapped to 0).
- Round-robin fairness: hold encoder_in_dut=0x0003 continuously in mode 1 → grants alternate 1,2,1,2. The same input in mode 0 → grants 1,1,1.
- Backpressure:
  - Stimulus: pulse 0x0001, ready=0 for 4 cycles while pulsing 0x0100.
  - Response: binary_out_dut stays 1, valid stays 1, pending=0x0100. Then release ready → grant 9 on the next cycle.
- Enable and set-wins:
  - enable=0 with encoder_in_dut=0xFFFF → pending unchanged, no grant.
  - Re-pulse bit 2 in the same cycle it is loaded → pending bit 2 remains set, and bit 2 is granted twice in total.
